wb_port_arbiter: RTL and testbench

- Sequences the single register-file write port between two writeback producers.
  - Source 0: the ALU/link writeback value.
  - Source 1: the load / long-latency result path.
- Each source has a valid/ready handshake into its own small FIFO.
- A round-robin scheduler pops one entry per cycle and drives registered register-file write controls.
- Sits between the writeback value selection and the register file. Writes to XZR (X31) are suppressed.

---
 rtl/wb_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-source writeback arbiter onto the single register-file write port
//
// Purpose: each writeback producer pushes (reg, data) pairs into its own small
// FIFO through a valid/ready handshake. A round-robin scheduler pops one head
// per cycle and drives registered register-file write controls. Writes to XZR
// (X31) consume a slot but never raise rf_we.
//
// Optional build macro: WB_CONFLICT_CNT_EN adds a saturating 16-bit count of
// cycles in which both FIFO heads are valid and no flush is pending.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   s0_valid/ready/reg/data source 0 (ALU/link) write handshake
//   s1_valid/ready/reg/data source 1 (load/long-latency) write handshake
//   flush                  synchronous discard of all queued writes
//   rf_we/rf_waddr/rf_wdata registered register-file write controls
//   idle                   both FIFOs empty and no write in flight
//   conflict_cnt           (WB_CONFLICT_CNT_EN only) contention cycle count

module wb_port_arbiter #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [REG_AW-1:0] s0_reg,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [REG_AW-1:0] s1_reg,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              flush,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              idle
`ifdef WB_CONFLICT_CNT_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [REG_AW-1:0] XZR = REG_AW'(31);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]       wr_ptr [2];
    logic [PW:0]       rd_ptr [2];
    logic [REG_AW-1:0] reg_mem  [2][DEPTH];
    logic [DATA_W-1:0] data_mem [2][DEPTH];

    logic [1:0]        empty;
    logic [1:0]        full;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        in_valid;
    logic [REG_AW-1:0] in_reg  [2];
    logic [DATA_W-1:0] in_data [2];

    logic              last_grant;
    logic              gnt;
    logic              both_valid;
    logic              pop_any;
    logic [REG_AW-1:0] head_reg;
    logic [DATA_W-1:0] head_data;

    assign in_valid   = {s1_valid, s0_valid};
    assign in_reg[0]  = s0_reg;
    assign in_reg[1]  = s1_reg;
    assign in_data[0] = s0_data;
    assign in_data[1] = s1_data;

    // Ready depends only on state and flush; a pop in the same cycle never
    // frees space for a push into a full FIFO.
    assign s0_ready = !full[0] && !flush;
    assign s1_ready = !full[1] && !flush;
    assign push     = in_valid & {s1_ready, s0_ready};

    assign both_valid = !empty[0] && !empty[1];
    assign pop_any    = !flush && !(empty[0] && empty[1]);
    // Contention goes to the source that did not win last; otherwise the
    // only non-empty FIFO wins (empty[0] set means source 1 is the one).
    assign gnt        = both_valid ? !last_grant : empty[0];
    assign pop        = pop_any ? (gnt ? 2'b10 : 2'b01) : 2'b00;

    assign head_reg  = reg_mem[gnt][rd_ptr[gnt][PW-1:0]];
    assign head_data = data_mem[gnt][rd_ptr[gnt][PW-1:0]];

    for (genvar g = 0; g < 2; g++) begin : g_fifo
        assign empty[g] = (wr_ptr[g] == rd_ptr[g]);
        assign full[g]  = (wr_ptr[g][PW] != rd_ptr[g][PW]) &&
                          (wr_ptr[g][PW-1:0] == rd_ptr[g][PW-1:0]);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wr_ptr[g] <= '0;
                rd_ptr[g] <= '0;
            end else if (flush) begin
                rd_ptr[g] <= wr_ptr[g];
            end else begin
                if (push[g]) wr_ptr[g] <= wr_ptr[g] + 1'b1;
                if (pop[g])  rd_ptr[g] <= rd_ptr[g] + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (push[g]) begin
                reg_mem[g][wr_ptr[g][PW-1:0]]  <= in_reg[g];
                data_mem[g][wr_ptr[g][PW-1:0]] <= in_data[g];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
        end else if (pop_any) begin
            last_grant <= gnt;
            rf_we      <= (head_reg != XZR);
            rf_waddr   <= head_reg;
            rf_wdata   <= head_data;
        end else begin
            rf_we      <= 1'b0;
        end
    end

    assign idle = empty[0] && empty[1] && !rf_we;

`ifdef WB_CONFLICT_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt <= '0;
        end else if (both_valid && !flush && conflict_cnt != 16'hFFFF) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter

module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s0_valid = 1'b0;
    logic        s0_ready;
    logic [4:0]  s0_reg = '0;
    logic [63:0] s0_data = '0;
    logic        s1_valid = 1'b0;
    logic        s1_ready;
    logic [4:0]  s1_reg = '0;
    logic [63:0] s1_data = '0;
    logic        flush = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        idle;
`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    int checks = 0;
    int failures = 0;

    logic [68:0] q0[$];
    logic [68:0] q1[$];
    logic [68:0] wlog[$];

    wb_port_arbiter #(.DATA_W(64), .REG_AW(5), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_reg(s0_reg), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_reg(s1_reg), .s1_data(s1_data),
        .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .idle(idle)
`ifdef WB_CONFLICT_CNT_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_we === 1'b1) wlog.push_back({rf_waddr, rf_wdata});
    end

    function automatic logic [63:0] dat(input logic [4:0] r);
        return 64'hC0DE_0000_0000_0000 | {59'd0, r} | ({59'd0, r} << 20);
    endfunction

    function automatic logic [68:0] ent(input logic [4:0] r);
        return {r, dat(r)};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        flush = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wlog.delete();
    endtask

    task automatic run_queues(input int budget, output int stalls1, output int acc1_first);
        int cyc;
        int acc1;
        cyc = 0;
        acc1 = 0;
        stalls1 = 0;
        acc1_first = -1;
        forever begin
            @(negedge clk);
            s0_valid = (q0.size() != 0);
            if (s0_valid) {s0_reg, s0_data} = q0[0];
            s1_valid = (q1.size() != 0);
            if (s1_valid) {s1_reg, s1_data} = q1[0];
            if (!s0_valid && !s1_valid && idle === 1'b1) break;
            #1;
            if (s0_valid && s0_ready) void'(q0.pop_front());
            if (s1_valid) begin
                if (s1_ready) begin
                    void'(q1.pop_front());
                    acc1++;
                end else begin
                    stalls1++;
                    if (acc1_first < 0) acc1_first = acc1;
                end
            end
            cyc++;
            if (cyc > budget) begin
                checks++;
                failures++;
                $display("FAIL run_timeout: still busy after %0d cycles, required idle", cyc);
                q0.delete();
                q1.delete();
                s0_valid = 1'b0;
                s1_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0) begin failures++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
        checks++; if (rf_wdata !== 64'd0) begin failures++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b want 1", idle); end
        checks++; if ({s0_ready, s1_ready} !== 2'b11) begin failures++; $display("FAIL reset_ready: got %b want 11", {s0_ready, s1_ready}); end
        // Mid-traffic: one write in flight and one entry still queued.
        @(negedge clk);
        s0_valid = 1'b1; {s0_reg, s0_data} = ent(5'd3);
        s1_valid = 1'b1; {s1_reg, s1_data} = ent(5'd9);
        @(negedge clk);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin failures++; $display("FAIL pre_reset_write: got we=%b addr=%0d want we=1 addr=3", rf_we, rf_waddr); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({rf_we, rf_waddr, rf_wdata} !== 70'd0) begin failures++; $display("FAIL async_reset_out: got we=%b addr=%0d data=%h want 0", rf_we, rf_waddr, rf_wdata); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL async_reset_idle: got %b want 1", idle); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++; if ({s0_ready, s1_ready, idle} !== 3'b111) begin failures++; $display("FAIL post_reset_ready_idle: got %b want 111", {s0_ready, s1_ready, idle}); end
        wlog.delete();
    endtask

    task automatic test_single_write();
        do_reset();
        s0_valid = 1'b1; {s0_reg, s0_data} = {5'd3, 64'hDEAD_BEEF};
        @(negedge clk);
        s0_valid = 1'b0;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL single_early: got we=%b want 0", rf_we); end
        @(negedge clk);
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 64'hDEAD_BEEF) begin
            failures++; $display("FAIL single_write: got we=%b addr=%0d data=%h want we=1 addr=3 data=deadbeef", rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        checks++; if (rf_we !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL single_after: got we=%b idle=%b want we=0 idle=1", rf_we, idle); end
        checks++; if (rf_waddr !== 5'd3 || rf_wdata !== 64'hDEAD_BEEF) begin failures++; $display("FAIL single_hold: got addr=%0d data=%h want 3 deadbeef", rf_waddr, rf_wdata); end
    endtask

    task automatic test_contention();
        logic [4:0] exp[$];
        int st, af;
        do_reset();
        q0 = '{ent(5'd1), ent(5'd2), ent(5'd3)};
        q1 = '{ent(5'd9), ent(5'd10), ent(5'd11)};
        exp = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
        run_queues(60, st, af);
        checks++; if (wlog.size() != exp.size()) begin failures++; $display("FAIL contention_count: got %0d want %0d", wlog.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= wlog.size()) begin failures++; $display("FAIL contention_order[%0d]: missing, want reg %0d", i, exp[i]); end
            else if (wlog[i] !== ent(exp[i])) begin failures++; $display("FAIL contention_order[%0d]: got %h want %h", i, wlog[i], ent(exp[i])); end
        end
`ifdef WB_CONFLICT_CNT_EN
        checks++; if (conflict_cnt == 16'd0) begin failures++; $display("FAIL conflict_cnt: got 0 want >0"); end
`endif
    endtask

    task automatic test_backpressure();
        logic [4:0] exp[$];
        int st, af;
        do_reset();
        q0 = '{ent(5'd4), ent(5'd5), ent(5'd6), ent(5'd7)};
        q1 = '{ent(5'd12), ent(5'd13), ent(5'd14), ent(5'd15)};
        exp = '{5'd4, 5'd12, 5'd5, 5'd13, 5'd6, 5'd14, 5'd7, 5'd15};
        run_queues(80, st, af);
        checks++; if (st == 0) begin failures++; $display("FAIL bp_stall: got 0 stall cycles want >0"); end
        checks++; if (af != 2) begin failures++; $display("FAIL bp_accepts_before_stall: got %0d want 2", af); end
        checks++; if (wlog.size() != exp.size()) begin failures++; $display("FAIL bp_count: got %0d want %0d", wlog.size(), exp.size()); end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= wlog.size()) begin failures++; $display("FAIL bp_order[%0d]: missing, want reg %0d", i, exp[i]); end
            else if (wlog[i] !== ent(exp[i])) begin failures++; $display("FAIL bp_order[%0d]: got %h want %h", i, wlog[i], ent(exp[i])); end
        end
    endtask

    task automatic test_xzr();
        int st, af;
        do_reset();
        q0 = '{ent(5'd2)};
        run_queues(20, st, af);
        q1 = '{{5'd31, 64'h1}};
        run_queues(20, st, af);
        // The X31 grant went to source 1, so source 0 wins the next contention.
        q0 = '{ent(5'd5)};
        q1 = '{ent(5'd20)};
        run_queues(20, st, af);
        checks++; if (wlog.size() != 3) begin failures++; $display("FAIL xzr_count: got %0d want 3", wlog.size()); end
        checks++; if (wlog.size() > 0 && wlog[0] !== ent(5'd2)) begin failures++; $display("FAIL xzr_first: got %h want %h", wlog[0], ent(5'd2)); end
        checks++; if (wlog.size() > 1 && wlog[1] !== ent(5'd5)) begin failures++; $display("FAIL xzr_rr_s0: got %h want %h", wlog[1], ent(5'd5)); end
        checks++; if (wlog.size() > 2 && wlog[2] !== ent(5'd20)) begin failures++; $display("FAIL xzr_rr_s1: got %h want %h", wlog[2], ent(5'd20)); end
    endtask

    task automatic test_flush();
        int st, af;
        do_reset();
        s0_valid = 1'b1; {s0_reg, s0_data} = ent(5'd1);
        s1_valid = 1'b1; {s1_reg, s1_data} = ent(5'd9);
        @(negedge clk);
        {s0_reg, s0_data} = ent(5'd2);
        {s1_reg, s1_data} = ent(5'd10);
        @(negedge clk);
        flush = 1'b1;
        s1_valid = 1'b0;
        {s0_reg, s0_data} = ent(5'd3);
        #1;
        checks++; if (s0_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", s0_ready); end
        @(negedge clk);
        flush = 1'b0;
        s0_valid = 1'b0;
        #1;
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL flush_idle: got %b want 1", idle); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL flush_we: got %b want 0", rf_we); end
        repeat (3) @(negedge clk);
        checks++; if (wlog.size() != 1 || wlog[0] !== ent(5'd1)) begin failures++; $display("FAIL flush_log: got %0d writes want only reg 1", wlog.size()); end
        // last_grant survives the flush (source 0 won last), so source 1 goes first now.
        wlog.delete();
        q0 = '{ent(5'd4)};
        q1 = '{ent(5'd12)};
        run_queues(20, st, af);
        checks++; if (wlog.size() != 2 || wlog[0] !== ent(5'd12) || wlog[1] !== ent(5'd4)) begin
            failures++; $display("FAIL flush_keep_grant: got %0d writes first=%h want 12 then 4", wlog.size(), (wlog.size() > 0) ? wlog[0] : 69'd0);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_backpressure();
        test_xzr();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
